// File: rtl/alu_op_sequencer_if.sv
// Byte-stream input and result-output handshakes of the ALU operand sequencer.
// The master side is the producer/consumer; the slave side is the sequencer.
interface alu_op_sequencer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_err;
    logic             res_valid;
    logic             res_ready;

    modport master (
        output in_data, in_valid, res_ready,
        input  in_ready, res_data, res_err, res_valid
    );

    modport slave (
        input  in_data, in_valid, res_ready,
        output in_ready, res_data, res_err, res_valid
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Collects A, B and opcode bytes, issues one ALU operation, waits a fixed
// latency, then holds the captured result until the consumer takes it.
//
// state  | meaning
// GET_A  | waiting for operand A byte (idle)
// GET_B  | waiting for operand B byte
// GET_OP | waiting for opcode byte
// ISSUE  | alu_do asserted for this single cycle
// WAIT   | counting down the ALU latency
// HOLD   | result presented until res_valid/res_ready handshake
module alu_op_sequencer #(
    parameter int WIDTH   = 8,
    parameter int SEL_W   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic               clk,
    input  logic               reset,
    alu_op_sequencer_if.slave  bus,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [SEL_W-1:0]   alu_sel,
    output logic               alu_do,
    input  logic [WIDTH-1:0]   alu_y,
    output logic               busy,
    output logic [7:0]         op_count
);

    typedef enum logic [2:0] {
        GET_A,
        GET_B,
        GET_OP,
        ISSUE,
        WAIT,
        HOLD
    } state_t;

    state_t     state;
    logic [3:0] lat_cnt;
    logic       in_xfer;

    assign in_xfer = bus.in_valid & bus.in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= GET_A;
            lat_cnt       <= 4'd0;
            alu_a         <= '0;
            alu_b         <= '0;
            alu_sel       <= '0;
            alu_do        <= 1'b0;
            busy          <= 1'b0;
            op_count      <= 8'd0;
            bus.in_ready  <= 1'b0;
            bus.res_data  <= '0;
            bus.res_err   <= 1'b0;
            bus.res_valid <= 1'b0;
        end else begin
            alu_do <= 1'b0;
            case (state)
                GET_A: begin
                    bus.in_ready <= 1'b1;
                    if (in_xfer) begin
                        alu_a <= bus.in_data;
                        busy  <= 1'b1;
                        state <= GET_B;
                    end
                end
                GET_B: begin
                    bus.in_ready <= 1'b1;
                    if (in_xfer) begin
                        alu_b <= bus.in_data;
                        state <= GET_OP;
                    end
                end
                GET_OP: begin
                    bus.in_ready <= 1'b1;
                    if (in_xfer) begin
                        bus.in_ready <= 1'b0;
                        // Upper opcode bits set: reject without touching the ALU
                        if (|bus.in_data[WIDTH-1:SEL_W]) begin
                            bus.res_data  <= '0;
                            bus.res_err   <= 1'b1;
                            bus.res_valid <= 1'b1;
                            state         <= HOLD;
                        end else begin
                            alu_sel <= bus.in_data[SEL_W-1:0];
                            alu_do  <= 1'b1;
                            state   <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    lat_cnt <= 4'(ALU_LAT);
                    state   <= WAIT;
                end
                WAIT: begin
                    if (lat_cnt == 4'd1) begin
                        lat_cnt       <= 4'd0;
                        bus.res_data  <= alu_y;
                        bus.res_err   <= 1'b0;
                        bus.res_valid <= 1'b1;
                        state         <= HOLD;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                HOLD: begin
                    if (bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        busy          <= 1'b0;
                        op_count      <= op_count + 8'd1;
                        state         <= GET_A;
                    end
                end
                default: begin
                    state <= GET_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed scoreboard bench for alu_op_sequencer: one instance with ALU
// latency 1 and one with latency 4, each driven by a small behavioural ALU.
`timescale 1ns/1ps
module tb_alu_op_sequencer;
    localparam int LAT0 = 1;
    localparam int LAT1 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]      reset, in_valid, res_ready;
    logic [1:0][7:0] in_data;
    logic [1:0]      in_ready, res_valid, res_err, alu_do, busy;
    logic [1:0][7:0] res_data, alu_a, alu_b, op_count;
    logic [1:0][7:0] alu_y = '0;
    logic [1:0][3:0] alu_sel;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    logic [8:0] exp_q[$];
    logic [1:0][15:0] do_cnt  = '0;
    logic [1:0]       do_prev = '0;
    logic [1:0]       do_dbl  = '0;

    alu_op_sequencer_if #(.WIDTH(8)) bus0();
    alu_op_sequencer_if #(.WIDTH(8)) bus1();

    assign bus0.in_data   = in_data[0];
    assign bus0.in_valid  = in_valid[0];
    assign bus0.res_ready = res_ready[0];
    assign in_ready[0]    = bus0.in_ready;
    assign res_valid[0]   = bus0.res_valid;
    assign res_err[0]     = bus0.res_err;
    assign res_data[0]    = bus0.res_data;

    assign bus1.in_data   = in_data[1];
    assign bus1.in_valid  = in_valid[1];
    assign bus1.res_ready = res_ready[1];
    assign in_ready[1]    = bus1.in_ready;
    assign res_valid[1]   = bus1.res_valid;
    assign res_err[1]     = bus1.res_err;
    assign res_data[1]    = bus1.res_data;

    alu_op_sequencer #(.WIDTH(8), .SEL_W(4), .ALU_LAT(LAT0)) u_dut0 (
        .clk(clk), .reset(reset[0]), .bus(bus0),
        .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_sel(alu_sel[0]), .alu_do(alu_do[0]),
        .alu_y(alu_y[0]), .busy(busy[0]), .op_count(op_count[0])
    );

    alu_op_sequencer #(.WIDTH(8), .SEL_W(4), .ALU_LAT(LAT1)) u_dut1 (
        .clk(clk), .reset(reset[1]), .bus(bus1),
        .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_sel(alu_sel[1]), .alu_do(alu_do[1]),
        .alu_y(alu_y[1]), .busy(busy[1]), .op_count(op_count[1])
    );

    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] sel);
        case (sel)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            default: return a;
        endcase
    endfunction

    // Behavioural ALU: result registered on the alu_do edge and held until the next issue.
    always_ff @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 2; k++) begin
            if (alu_do[k]) begin
                alu_y[k]  <= alu_fn(alu_a[k], alu_b[k], alu_sel[k]);
                do_cnt[k] <= do_cnt[k] + 16'd1;
            end
            if (alu_do[k] && do_prev[k]) do_dbl[k] <= 1'b1;
            do_prev[k] <= alu_do[k];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input int k, input logic [7:0] b);
        int guard = 0;
        in_data[k]  = b;
        in_valid[k] = 1'b1;
        while (in_ready[k] !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_wait", 32'(in_ready[k]), 32'd1);
        @(negedge clk);
    endtask

    task automatic send_op(input int k, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] op, input bit push);
        send_byte(k, a);
        send_byte(k, b);
        send_byte(k, op);
        if (push) begin
            if (op[7:4] != 4'd0) exp_q.push_back({1'b1, 8'h00});
            else                 exp_q.push_back({1'b0, alu_fn(a, b, op[3:0])});
        end
    endtask

    task automatic get_result(input int k, input string tag, output int seen);
        int guard = 0;
        logic [8:0] e;
        while (res_valid[k] !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        seen = cyc;
        check({tag, "_valid"}, 32'(res_valid[k]), 32'd1);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else                  e = 'x;
        check({tag, "_res"}, 32'({res_err[k], res_data[k]}), 32'(e));
        @(negedge clk);
    endtask

    task automatic run_b2b(input int k, input int n, input int lat);
        int bad_spacing = 0;
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    logic [7:0] a, b, op;
                    a  = 8'(i);
                    b  = 8'(i * 7 + 3);
                    op = 8'(i % 6);
                    send_op(k, a, b, op, 1'b1);
                end
                in_valid[k] = 1'b0;
            end
            begin
                int prev = 0;
                int seen;
                for (int i = 0; i < n; i++) begin
                    get_result(k, "b2b", seen);
                    if (i > 0 && seen - prev != 5 + lat) bad_spacing++;
                    prev = seen;
                end
            end
        join
        check("b2b_spacing_errors", 32'(bad_spacing), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, seen, oc, rv_seen;
        logic [15:0] d0;

        reset     = 2'b11;
        in_valid  = 2'b00;
        res_ready = 2'b11;
        in_data   = '0;
        repeat (3) @(negedge clk);

        check("rst_in_ready",  32'(in_ready[0]),  32'd0);
        check("rst_res_valid", 32'(res_valid[0]), 32'd0);
        check("rst_busy",      32'(busy[0]),      32'd0);
        check("rst_alu_do",    32'(alu_do[0]),    32'd0);
        check("rst_op_count",  32'(op_count[0]),  32'd0);
        check("rst_operands",  32'({alu_a[0], alu_b[0], alu_sel[0]}), 32'd0);
        check("rst_res_data",  32'({res_err[0], res_data[0]}), 32'd0);

        reset = 2'b00;
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready[0]), 32'd1);
        check("idle_busy",     32'(busy[0]),     32'd0);

        // Basic add with latency check
        d0 = do_cnt[0];
        send_op(0, 8'h05, 8'h03, 8'h00, 1'b1);
        t0 = cyc;
        in_valid[0] = 1'b0;
        check("busy_in_issue", 32'(busy[0]), 32'd1);
        get_result(0, "add", seen);
        check("add_latency", 32'(seen - t0), 32'(1 + LAT0));
        check("add_op_count", 32'(op_count[0]), 32'd1);
        check("add_do_pulses", 32'(do_cnt[0] - d0), 32'd1);

        send_op(0, 8'h10, 8'h20, 8'h01, 1'b1);
        in_valid[0] = 1'b0;
        get_result(0, "sub", seen);

        send_op(0, 8'hFF, 8'h02, 8'h00, 1'b1);
        in_valid[0] = 1'b0;
        get_result(0, "wrap_add", seen);

        send_op(0, 8'h0F, 8'hF0, 8'h04, 1'b1);
        in_valid[0] = 1'b0;
        get_result(0, "xor", seen);

        // Reserved opcode: no issue, select retained
        d0 = do_cnt[0];
        oc = int'(op_count[0]);
        send_op(0, 8'h10, 8'h20, 8'h35, 1'b1);
        in_valid[0] = 1'b0;
        get_result(0, "reserved", seen);
        check("reserved_no_do", 32'(do_cnt[0] - d0), 32'd0);
        check("reserved_sel_kept", 32'(alu_sel[0]), 32'd4);
        check("reserved_operands", 32'({alu_a[0], alu_b[0]}), 32'h1020);
        check("reserved_op_count", 32'(op_count[0]), 32'((oc + 1) % 256));

        // Backpressure with gaps and the next A offered during HOLD
        res_ready[0] = 1'b0;
        send_byte(0, 8'h33);
        in_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        send_byte(0, 8'h11);
        in_valid[0] = 1'b0;
        @(negedge clk);
        send_byte(0, 8'h01);
        exp_q.push_back({1'b0, 8'h22});
        in_data[0]  = 8'h77;
        begin
            int guard = 0;
            while (res_valid[0] !== 1'b1 && guard < 100) begin
                @(negedge clk);
                guard++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_res_valid", 32'(res_valid[0]), 32'd1);
            check("bp_res_data",  32'({res_err[0], res_data[0]}), 32'h022);
            check("bp_in_ready",  32'(in_ready[0]), 32'd0);
            @(negedge clk);
        end
        check("bp_a_not_taken", 32'(alu_a[0]), 32'h33);
        res_ready[0] = 1'b1;
        get_result(0, "bp", seen);
        send_op(0, 8'h77, 8'h01, 8'h00, 1'b1);
        in_valid[0] = 1'b0;
        check("bp_a_accepted", 32'(alu_a[0]), 32'h77);
        get_result(0, "bp_next", seen);

        // Latency-4 instance: one complete op, then reset mid-WAIT
        @(negedge clk);
        send_op(1, 8'h40, 8'h02, 8'h00, 1'b1);
        t0 = cyc;
        in_valid[1] = 1'b0;
        get_result(1, "lat4_add", seen);
        check("lat4_latency", 32'(seen - t0), 32'(1 + LAT1));
        check("lat4_op_count", 32'(op_count[1]), 32'd1);

        send_op(1, 8'h01, 8'h02, 8'h00, 1'b0);
        in_valid[1] = 1'b0;
        check("midwait_do", 32'(alu_do[1]), 32'd1);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1 reset[1] = 1'b1;
        #1;
        check("midwait_ctl", 32'({in_ready[1], busy[1], res_valid[1], res_err[1], alu_do[1]}), 32'd0);
        check("midwait_operands", 32'({alu_a[1], alu_b[1], alu_sel[1]}), 32'd0);
        check("midwait_op_count", 32'(op_count[1]), 32'd0);
        check("midwait_res_data", 32'(res_data[1]), 32'd0);
        repeat (3) @(negedge clk);
        reset[1] = 1'b0;
        rv_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (res_valid[1] !== 1'b0) rv_seen++;
        end
        check("midwait_no_result", 32'(rv_seen), 32'd0);
        send_op(1, 8'h01, 8'h01, 8'h00, 1'b1);
        in_valid[1] = 1'b0;
        get_result(1, "after_reset", seen);

        run_b2b(1, 3, LAT1);

        // 256 back-to-back ops on the latency-1 instance wrap op_count to zero
        reset[0] = 1'b1;
        @(negedge clk);
        check("wrap_start_count", 32'(op_count[0]), 32'd0);
        reset[0] = 1'b0;
        @(negedge clk);
        run_b2b(0, 256, LAT0);
        check("wrap_op_count", 32'(op_count[0]), 32'd0);
        check("no_double_do", 32'(do_dbl), 32'd0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Upstream operand and opcode sequencer for the 8-bit two's-complement ALU stage.
- Collects three bytes from a byte-wide valid/ready input stream: operand A, operand B, opcode.
- Presents A, B and select to the ALU, pulses `do` for one cycle, then waits a fixed ALU latency and captures the ALU result.
- Returns the captured result on a valid/ready output port, with an error flag and a completed-operation counter.

Parameters:
- WIDTH, 8, operand/result width.
- SEL_W, 4, ALU select width.
- ALU_LAT, 1, cycles from the `do`-sampling edge to valid `alu_y`. Legal range 1..15.

Ports:
- clk, input, 1, clock.
- reset, input, 1, reset; asynchronous, active-high.
- in_data, input, WIDTH, byte stream carrying A, then B, then opcode.
- in_valid, input, 1, in_data valid.
- in_ready, output, 1, sequencer accepts in_data.
- alu_a, output, WIDTH, operand A to the ALU.
- alu_b, output, WIDTH, operand B to the ALU.
- alu_sel, output, SEL_W, ALU select.
- alu_do, output, 1, one-cycle issue strobe to the ALU.
- alu_y, input, WIDTH, ALU result.
- res_data, output, WIDTH, captured result.
- res_err, output, 1, reserved opcode rejected.
- res_valid, output, 1, result available.
- res_ready, input, 1, consumer accepts result.
- busy, output, 1, high in any state except GET_A.
- op_count, output, 8, completed transactions, wraps at 255 to 0.

Behaviour:
- Reset (async, any state, mid-transaction included):
  - State goes to GET_A.
  - All outputs go to 0, including in_ready, so in_ready is 0 during reset.
  - Any partial transaction is discarded.
- A transfer occurs on a rising edge where in_valid and in_ready are both 1.
- Result handshake completes on a rising edge where res_valid and res_ready are both 1.
- States and transitions:
  - GET_A: in_ready=1. On transfer, alu_a<=in_data, go to GET_B.
  - GET_B: in_ready=1. On transfer, alu_b<=in_data, go to GET_OP.
  - GET_OP: in_ready=1. On transfer:
    - If in_data[7:SEL_W]!=0 (reserved opcode): alu_sel unchanged, res_data<=0, res_err<=1, go to HOLD. No alu_do is issued.
    - Otherwise: alu_sel<=in_data[SEL_W-1:0], go to ISSUE.
  - ISSUE: alu_do=1 for exactly this one cycle. Latency counter loads ALU_LAT. Go to WAIT.
  - WAIT: counter decrements each cycle. On the edge where the counter reaches 0, i.e. ALU_LAT edges after the alu_do edge: res_data<=alu_y, res_err<=0, go to HOLD.
  - HOLD: res_valid=1. res_data and res_err held stable until the handshake. On handshake: op_count<=op_count+1, go to GET_A. Rejected ops also increment op_count.
- in_ready is 0 in ISSUE, WAIT and HOLD. Input bytes offered during those states are neither consumed nor lost; the producer holds them.
- alu_a, alu_b and alu_sel are registered and stable from capture until the next capture of the same field. They do not change during ISSUE or WAIT.
- in_valid gaps between bytes are allowed; the state is held.
- res_ready held high throughout: HOLD lasts exactly one cycle.
- Throughput floor with no stalls: 3 + 1 + ALU_LAT + 1 cycles per operation.
- alu_do is never asserted outside ISSUE and never for two consecutive cycles.
- op_count is unsigned 8-bit with modular wrap; there is no saturation.

Test Plan:
- Basic add, ALU_LAT=1, bench ALU registers a+b on alu_do:
  - Stimulus: stream 0x05, 0x03, 0x00, res_ready=1.
  - Response: alu_do high exactly one cycle; res_valid the cycle after capture with res_data=0x08, res_err=0; op_count=1.
- Wrap-around add: stream 0xFF, 0x02, 0x00 -> res_data=0x01, res_err=0.
- Reserved opcode: stream 0x10, 0x20, 0x35 -> no alu_do pulse; alu_sel keeps its previous value; res_data=0x00, res_err=1; op_count increments.
- Backpressure and gaps:
  - Stimulus: res_ready low 5 cycles in HOLD; in_valid toggled between bytes; next A=0x77 offered during HOLD.
  - Response: res_data stable; in_ready=0 until the handshake; 0x77 is then accepted as A.
- Reset mid-WAIT, ALU_LAT=4:
  - Stimulus: assert reset two cycles after alu_do.
  - Response: all outputs 0 immediately; no res_valid; the next stream 0x01, 0x01, 0x00 yields res_data=0x02.
- Counter wrap: run 256 back-to-back ops -> op_count returns to 0x00; measured spacing equals 5+ALU_LAT cycles per op.
